// File: rtl/colparity_controller.sv
// Purpose: sequences the theta column-parity (C-array) step over a 5x5x64 state, one bit per read.
// Latency: 7 cycles per (z,x) column, 320 columns; done pulses 2241 cycles after start is sampled.
// Backpressure: none; start is accepted only in IDLE and ignored otherwise.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start / ready       run request (sampled in IDLE) / idle indication
//   done                one-cycle pulse after the last parity write
//   in_rd, in_bit       input-memory read strobe / read data (valid one cycle after in_rd)
//   x_idx, y_idx, z_idx read address; (x_idx, z_idx) is also the write address
//   wr_en, wr_data      output-memory write strobe / parity bit
module colparity_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       ready,
    output logic       done,
    output logic       in_rd,
    output logic [2:0] x_idx,
    output logic [2:0] y_idx,
    output logic [5:0] z_idx,
    input  logic       in_bit,
    output logic       wr_en,
    output logic       wr_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0] state;
    logic [2:0] x_q;
    logic [2:0] y_q;
    logic [5:0] z_q;
    logic       acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            x_q   <= 3'd0;
            y_q   <= 3'd0;
            z_q   <= 6'd0;
            acc   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_READ;
                        x_q   <= 3'd0;
                        y_q   <= 3'd0;
                        z_q   <= 6'd0;
                        acc   <= 1'b0;
                    end
                end
                S_READ: begin
                    // in_bit now carries the row requested last cycle; at y=0
                    // nothing of this column has been requested yet.
                    if (y_q != 3'd0) begin
                        acc <= acc ^ in_bit;
                    end
                    if (y_q == 3'd4) begin
                        y_q   <= 3'd0;
                        state <= S_WAIT;
                    end else begin
                        y_q <= y_q + 3'd1;
                    end
                end
                S_WAIT: begin
                    // Absorbs the y=4 data returned by the synchronous memory.
                    acc   <= acc ^ in_bit;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    acc <= 1'b0;
                    if (x_q == 3'd4) begin
                        x_q <= 3'd0;
                        // The 6-bit slice counter wraps 63 -> 0 on the last column.
                        z_q <= z_q + 6'd1;
                        state <= (z_q == 6'd63) ? S_DONE : S_READ;
                    end else begin
                        x_q   <= x_q + 3'd1;
                        state <= S_READ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only; no path from start or in_bit.
    assign ready   = (state == S_IDLE);
    assign done    = (state == S_DONE);
    assign in_rd   = (state == S_READ);
    assign wr_en   = (state == S_WRITE);
    assign wr_data = (state == S_WRITE) & acc;
    assign x_idx   = x_q;
    assign y_idx   = y_q;
    assign z_idx   = z_q;

endmodule

// File: tb/tb_colparity_controller.sv
module tb_colparity_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ready, done, in_rd, wr_en, wr_data;
    logic [2:0] x_idx, y_idx;
    logic [5:0] z_idx;
    logic       in_bit = 1'b0;

    colparity_controller dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .ready  (ready),
        .done   (done),
        .in_rd  (in_rd),
        .x_idx  (x_idx),
        .y_idx  (y_idx),
        .z_idx  (z_idx),
        .in_bit (in_bit),
        .wr_en  (wr_en),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Input state array A[x][y][z]
    bit mem [5][5][64];

    // Synchronous 1-bit memory; returns noise when not read so ignored
    // cycles really must be ignored.
    always @(posedge clk) begin
        if (in_rd && x_idx < 5 && y_idx < 5)
            in_bit <= mem[x_idx][y_idx][z_idx];
        else
            in_bit <= 1'($urandom);
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit parity(input int x, input int z);
        bit p = 1'b0;
        for (int y = 0; y < 5; y++) p ^= mem[x][y][z];
        return p;
    endfunction

    // Model: d_run = cycles since the accepted start (0 = IDLE).
    int d_run = 0;
    bit model_valid = 1'b0;
    // Per-run observations of the DUT, compared to literals by the driver.
    int wr_cnt, ones_cnt, one_d, done_cnt, done_d;

    always @(posedge clk) begin
        if (reset) begin
            d_run = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (d_run == 0) begin
                if (start) begin
                    d_run = 1;
                    wr_cnt = 0; ones_cnt = 0; one_d = -1; done_cnt = 0; done_d = -1;
                end
            end else if (d_run == 2241) begin
                d_run = 0;
            end else begin
                d_run++;
            end
        end
    end

    // Per-cycle compare against the column schedule.
    always @(negedge clk) begin
        if (model_valid) begin
            int d, p, k;
            int e_x, e_y, e_z;
            bit e_rd, e_wr, e_dat;
            d = d_run;
            e_x = 0; e_y = 0; e_z = 0; e_rd = 0; e_wr = 0; e_dat = 0;
            if (d >= 1 && d <= 2240) begin
                p = (d - 1) % 7;
                k = (d - 1) / 7;
                e_x = k % 5;
                e_z = k / 5;
                e_y = (p < 5) ? p : 0;
                e_rd = (p < 5);
                e_wr = (p == 6);
                if (e_wr) e_dat = parity(e_x, e_z);
            end
            check("ready", int'(ready), int'(d == 0));
            check("done",  int'(done),  int'(d == 2241));
            check("in_rd", int'(in_rd), int'(e_rd));
            check("wr_en", int'(wr_en), int'(e_wr));
            check("x_idx", int'(x_idx), e_x);
            check("y_idx", int'(y_idx), e_y);
            check("z_idx", int'(z_idx), e_z);
            if (e_wr) check("wr_data", int'(wr_data), int'(e_dat));
            if (wr_en) begin
                wr_cnt++;
                if (wr_data) begin ones_cnt++; one_d = d; end
            end
            if (done) begin done_cnt++; done_d = d; end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_d(input int target, input int budget, input string name);
        int n = 0;
        while (d_run != target && n < budget) begin
            step();
            n++;
        end
        check(name, d_run, target);
    endtask

    task automatic fill(input bit v);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++) mem[x][y][z] = v;
    endtask

    task automatic fill_rand();
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++) mem[x][y][z] = 1'($urandom);
    endtask

    task automatic run_once();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_d(0, 2400, "run_end");
    endtask

    initial begin
        repeat (3) step();
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_in_rd", int'(in_rd), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_idx", int'({x_idx, y_idx, z_idx}), 0);
        reset = 1'b0;
        repeat ($urandom_range(1, 4)) step();

        // All-zero memory
        fill(1'b0);
        run_once();
        check("zero_wr_cnt", wr_cnt, 320);
        check("zero_ones", ones_cnt, 0);
        check("zero_done_d", done_d, 2241);
        check("zero_done_cnt", done_cnt, 1);

        // Single set bit at (x=2,y=3,z=10) -> column k=52, written at T+371
        mem[2][3][10] = 1'b1;
        run_once();
        check("single_ones", ones_cnt, 1);
        check("single_at", one_d, 371);

        // All ones: five ones per column -> parity 1 everywhere
        fill(1'b1);
        run_once();
        check("ones_ones", ones_cnt, 320);

        // y=0 and y=4 of one column set -> that column writes 0
        fill(1'b0);
        mem[1][0][7] = 1'b1;
        mem[1][4][7] = 1'b1;
        run_once();
        check("edge_rows_ones", ones_cnt, 0);

        // start held through the run and into DONE
        fill_rand();
        start = 1'b1;
        step();
        wait_d(2241, 2400, "held_done");
        step();
        check("held_idle", d_run, 0);
        check("held_ready", int'(ready), 1);
        check("held_done_cnt", done_cnt, 1);
        check("held_wr_cnt", wr_cnt, 320);
        step();
        check("held_restart", d_run, 1);
        check("held_restart_rd", int'(in_rd), 1);
        start = 1'b0;
        // back-to-back second run continues with the same data
        wait_d(0, 2400, "held_run2_end");
        check("run2_wr_cnt", wr_cnt, 320);
        check("run2_done_d", done_d, 2241);
        check("run2_z_wrap", int'(z_idx), 0);

        // Reset during column 14 READ phase
        fill_rand();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_d(100, 200, "mid_reach");
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_ready", int'(ready), 1);
        check("mid_in_rd", int'(in_rd), 0);
        check("mid_idx", int'({x_idx, y_idx, z_idx}), 0);
        repeat (20) step();
        check("mid_wr_cnt", wr_cnt, 14);
        run_once();
        check("post_wr_cnt", wr_cnt, 320);
        check("post_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
